// File: rtl/regfile_wr_port_scheduler.sv
// regfile_wr_port_scheduler
//   Round-robin scheduler that maps up to NUM_PORTS of NUM_REQ writeback
//   requests per cycle onto the register-file SRAM write ports. Requests that
//   share an address are never granted in the same cycle. Grants are registered
//   onto the write ports, one cycle after the handshake.
//   Optional feature: define RF_WR_STALL_CNT_EN to add stall_cnt_o, a saturating
//   16-bit count of cycles in which some valid requester was left waiting.
module regfile_wr_port_scheduler #(
  parameter int NUM_REQ    = 8,
  parameter int NUM_PORTS  = 6,
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0]    req_addr_i,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic [NUM_PORTS-1:0]             we_o,
  output logic [NUM_PORTS*SRAM_INDEX-1:0]  addrwr_o,
  output logic [NUM_PORTS*SRAM_WIDTH-1:0]  datawr_o
`ifdef RF_WR_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cnt_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_PORTS + 1);

  logic [PTR_W-1:0]               r_rr_ptr;
  logic [PTR_W-1:0]               w_rr_ptr_next;
  logic [PTR_W-1:0]               w_last_idx;
  logic [PTR_W-1:0]               w_idx;
  logic [PTR_W:0]                 w_sum;
  logic [CNT_W-1:0]               w_cnt;
  logic                           w_clash;
  logic                           w_any_grant;
  logic [NUM_REQ-1:0]             w_grant;
  logic [NUM_PORTS-1:0]           w_port_we;
  logic [NUM_PORTS*SRAM_INDEX-1:0] w_port_addr;
  logic [NUM_PORTS*SRAM_WIDTH-1:0] w_port_data;

  logic [NUM_PORTS-1:0]            r_we;
  logic [NUM_PORTS*SRAM_INDEX-1:0] r_addr;
  logic [NUM_PORTS*SRAM_WIDTH-1:0] r_data;

  // Scan requesters from r_rr_ptr; grant each valid one while ports remain and
  // its address is not already taken this cycle; k-th grant goes to port k.
  always_comb begin
    w_grant     = '0;
    w_port_we   = '0;
    w_port_addr = '0;
    w_port_data = '0;
    w_cnt       = '0;
    w_last_idx  = r_rr_ptr;
    w_sum       = '0;
    w_idx       = '0;
    w_clash     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_idx   = w_sum[PTR_W-1:0];
      w_clash = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_grant[j] &&
            (req_addr_i[j*SRAM_INDEX +: SRAM_INDEX] == req_addr_i[w_idx*SRAM_INDEX +: SRAM_INDEX])) begin
          w_clash = 1'b1;
        end
      end
      if (req_valid_i[w_idx] && (w_cnt < CNT_W'(NUM_PORTS)) && !w_clash) begin
        w_grant[w_idx]                           = 1'b1;
        w_port_we[w_cnt]                         = 1'b1;
        w_port_addr[w_cnt*SRAM_INDEX +: SRAM_INDEX] = req_addr_i[w_idx*SRAM_INDEX +: SRAM_INDEX];
        w_port_data[w_cnt*SRAM_WIDTH +: SRAM_WIDTH] = req_data_i[w_idx*SRAM_WIDTH +: SRAM_WIDTH];
        w_cnt                                    = w_cnt + CNT_W'(1);
        w_last_idx                               = w_idx;
      end
    end
  end

  assign w_any_grant   = |w_grant;
  assign w_rr_ptr_next = (w_last_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_last_idx + PTR_W'(1));

  // Grants are suppressed while reset is asserted so no handshake can occur.
  assign req_ready_o = reset ? '0 : w_grant;

  // Register the port image and advance the pointer past the last grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_we   <= w_port_we;
      r_addr <= w_port_addr;
      r_data <= w_port_data;
      if (w_any_grant) begin
        r_rr_ptr <= w_rr_ptr_next;
      end
    end
  end

  assign we_o     = r_we;
  assign addrwr_o = r_addr;
  assign datawr_o = r_data;

`ifdef RF_WR_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = |(req_valid_i & ~w_grant);

  // Count cycles where any valid requester was refused; saturate at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_regfile_wr_port_scheduler.sv
// tb_regfile_wr_port_scheduler
//   Scoreboard bench: each cycle a queue-based reference scheduler predicts the
//   grant mask and the next write-port image; a separate monitor pops and
//   compares after every clock edge. Directed scenarios then random traffic.
//   Define RF_WR_STALL_CNT_EN to also check stall_cnt_o.
module tb_regfile_wr_port_scheduler;

  localparam int NR = 8;
  localparam int NP = 6;
  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] data;
    int               stall;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid_i;
  logic [NR*AW-1:0]  req_addr_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic [NP-1:0]     we_o;
  logic [NP*AW-1:0]  addrwr_o;
  logic [NP*DW-1:0]  datawr_o;
`ifdef RF_WR_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
`endif

  logic [AW-1:0] t_addr [NR];
  logic [DW-1:0] t_data [NR];
  logic [NR-1:0] last_grant;
  int            m_ptr;
  int            m_stall;
  int            n_tests;
  int            n_fail;
  exp_t          exp_q[$];

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_addr_i[gi*AW +: AW] = t_addr[gi];
    assign req_data_i[gi*DW +: DW] = t_data[gi];
  end

  regfile_wr_port_scheduler #(
    .NUM_REQ(NR), .NUM_PORTS(NP), .SRAM_INDEX(AW), .SRAM_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .we_o(we_o),
    .addrwr_o(addrwr_o),
    .datawr_o(datawr_o)
`ifdef RF_WR_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: walk requesters from the pointer, keep a list of winners and the
  // addresses they claimed; winners fill ports in order of discovery.
  function automatic void ref_sched(output logic [NR-1:0] gmask, output exp_t e, output int next_ptr);
    int            winners[$];
    logic [AW-1:0] used[$];
    int            r;
    bit            dup;
    gmask    = '0;
    e.we     = '0;
    e.addr   = '0;
    e.data   = '0;
    e.stall  = m_stall;
    next_ptr = m_ptr;
    for (int i = 0; i < NR; i++) begin
      r   = (m_ptr + i) % NR;
      dup = 1'b0;
      foreach (used[u]) if (used[u] == t_addr[r]) dup = 1'b1;
      if (req_valid_i[r] && winners.size() < NP && !dup) begin
        winners.push_back(r);
        used.push_back(t_addr[r]);
      end
    end
    foreach (winners[k]) begin
      gmask[winners[k]]    = 1'b1;
      e.we[k]              = 1'b1;
      e.addr[k*AW +: AW]   = t_addr[winners[k]];
      e.data[k*DW +: DW]   = t_data[winners[k]];
    end
    if (winners.size() > 0) next_ptr = (winners[winners.size()-1] + 1) % NR;
  endfunction

  // One clock of traffic: predict, compare ready mid-cycle, enqueue the port
  // image expected after the edge, then advance the model pointer.
  task automatic step(input logic [NR-1:0] want, input bit chk_want);
    logic [NR-1:0] g;
    exp_t          e;
    int            np;
    ref_sched(g, e, np);
    @(negedge clk);
    check("ready_model", 64'(req_ready_o), 64'(g));
    if (chk_want) check("ready_const", 64'(req_ready_o), 64'(want));
    if ((req_valid_i & ~g) != '0 && m_stall < 65535) m_stall++;
    e.stall = m_stall;
    exp_q.push_back(e);
    last_grant = g;
    @(posedge clk);
    m_ptr = np;
    #1;
  endtask

  task automatic set_req(input int r, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[r] = v;
    t_addr[r]      = a;
    t_data[r]      = d;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, '0, '0);
  endtask

  // Assert reset mid-cycle, confirm outputs clear before the next edge, release.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_addr", 64'(addrwr_o), 64'd0);
    check("rst_data", 64'(datawr_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd0);
`ifdef RF_WR_STALL_CNT_EN
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
`endif
    exp_q.delete();
    m_ptr      = 0;
    m_stall    = 0;
    last_grant = '0;
    clear_reqs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: after every edge compare the port image with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("[TB] t=%0t we=%h addr=%h data=%h", $time, we_o, addrwr_o, datawr_o);
        check("port_we", 64'(we_o), 64'(e.we));
        check("port_addr", 64'(addrwr_o), 64'(e.addr));
        check("port_data", 64'(datawr_o), 64'(e.data));
`ifdef RF_WR_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt_o), 64'(e.stall));
`endif
      end
    end
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_ptr      = 0;
    m_stall    = 0;
    last_grant = '0;
    reset      = 1'b1;
    req_valid_i = '0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    check("init_we", 64'(we_o), 64'd0);
    check("init_addr", 64'(addrwr_o), 64'd0);
    check("init_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Six distinct requests from pointer 0 fill every port.
    for (int r = 0; r < 6; r++) set_req(r, 1'b1, AW'(r), DW'(8'h10 + r));
    step(8'h3F, 1'b1);
    check("t2_we", 64'(we_o), 64'h3F);
    clear_reqs();

    // Reset mid-cycle while all ports are writing, then req0 alone -> port 0.
    do_reset();
    set_req(0, 1'b1, 4'h7, 8'h5A);
    step(8'h01, 1'b1);
    check("t1_we", 64'(we_o), 64'h01);
    check("t1_data", 64'(datawr_o[DW-1:0]), 64'h5A);
    clear_reqs();

    // All eight valid with distinct addresses, two consecutive cycles.
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, AW'(r + 8), DW'(8'hA0 + r));
    step(8'h3F, 1'b1);
    step(8'hCF, 1'b1);
    check("t3_port0_addr", 64'(addrwr_o[AW-1:0]), 64'hE);
    clear_reqs();

    // Same-address collision: earliest in scan order wins, loser retries.
    do_reset();
    set_req(1, 1'b1, 4'hA, 8'h41);
    set_req(3, 1'b1, 4'hA, 8'h43);
    step(8'h02, 1'b1);
    check("t4_data0", 64'(datawr_o[DW-1:0]), 64'h41);
    set_req(1, 1'b0, '0, '0);
    step(8'h08, 1'b1);
    check("t4_data1", 64'(datawr_o[DW-1:0]), 64'h43);
    set_req(3, 1'b0, '0, '0);

    // Move pointer to 5, idle three cycles, then show pointer held.
    set_req(4, 1'b1, 4'h1, 8'h44);
    step(8'h10, 1'b1);
    clear_reqs();
    for (int c = 0; c < 3; c++) begin
      step(8'h00, 1'b1);
      check("t5_idle_we", 64'(we_o), 64'd0);
    end
    set_req(0, 1'b1, 4'h2, 8'h60);
    set_req(5, 1'b1, 4'h3, 8'h65);
    step(8'h21, 1'b1);
    check("t5_port0_addr", 64'(addrwr_o[AW-1:0]), 64'h3);
    clear_reqs();

`ifdef RF_WR_STALL_CNT_EN
    // Ten saturated cycles, then a forced near-max value must saturate.
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, AW'(r), DW'(r));
    for (int c = 0; c < 10; c++) step('0, 1'b0);
    check("t6_stall10", 64'(stall_cnt_o), 64'd10);
    force dut.r_stall_cnt = 16'hFFFF;
    #1;
    release dut.r_stall_cnt;
    m_stall = 65535;
    step('0, 1'b0);
    check("t6_stall_sat", 64'(stall_cnt_o), 64'hFFFF);
    clear_reqs();
`endif

    // Random traffic with a narrow address range to provoke collisions.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req_valid_i[r] || last_grant[r]) begin
          if ($urandom_range(99) < 65) set_req(r, 1'b1, AW'($urandom_range(7)), DW'($urandom));
          else                         set_req(r, 1'b0, '0, '0);
        end
      end
      step('0, 1'b0);
    end
    clear_reqs();
    step('0, 1'b0);
    @(posedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
